// File: rtl/mixed_radix_counter.sv
// Cascaded N-digit mixed-radix counter with per-digit terminal values,
// up/down counting, clamped parallel load and wrap-or-saturate behaviour.
// Drives display digit muxes and chains onward through the combinational CE.
module mixed_radix_counter #(
    parameter int          NUM_DIGITS = 4,
    parameter logic [31:0] MAX_LIST   = 32'h0000_9599
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      INC,
    input  logic                      DOWN,
    input  logic                      WRAP,
    input  logic                      LOAD,
    input  logic [4*NUM_DIGITS-1:0]   LOAD_VAL,
    output logic [4*NUM_DIGITS-1:0]   Q,
    output logic                      CE,
    output logic                      AT_MAX,
    output logic                      AT_ZERO,
    output logic                      SAT
);

    logic [4*NUM_DIGITS-1:0] q_q, q_d;
    logic                    sat_q, sat_d;
    logic                    at_max;
    logic                    at_zero;
    logic                    terminal;

    // Terminal detection works on the registered count only.
    always_comb begin
        at_max = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (q_q[4*i +: 4] != MAX_LIST[4*i +: 4]) begin
                at_max = 1'b0;
            end
        end
        at_zero  = (q_q == '0);
        terminal = DOWN ? at_zero : at_max;
    end

    // Next-state: load clamps each digit to its terminal value; counting
    // ripples a carry/borrow up from digit 0, which also yields the wrap.
    always_comb begin
        logic       carry;
        logic [3:0] dig;
        logic [3:0] mx;
        q_d   = q_q;
        sat_d = sat_q;
        carry = 1'b1;
        dig   = '0;
        mx    = '0;
        if (LOAD) begin
            sat_d = 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                mx  = MAX_LIST[4*i +: 4];
                dig = LOAD_VAL[4*i +: 4];
                q_d[4*i +: 4] = (dig > mx) ? mx : dig;
            end
        end else if (INC) begin
            if (terminal && !WRAP) begin
                sat_d = 1'b1;
            end else begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    mx  = MAX_LIST[4*i +: 4];
                    dig = q_q[4*i +: 4];
                    if (carry) begin
                        if (DOWN) begin
                            q_d[4*i +: 4] = (dig == 4'd0) ? mx : dig - 4'd1;
                        end else begin
                            q_d[4*i +: 4] = (dig == mx) ? 4'd0 : dig + 4'd1;
                        end
                    end
                    carry = carry & (DOWN ? (dig == 4'd0) : (dig == mx));
                end
            end
        end
    end

    // State registers; reset has top priority over load and count.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            q_q   <= '0;
            sat_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            sat_q <= sat_d;
        end
    end

    // Outputs; CE is independent of WRAP so chained stages see every terminal step.
    always_comb begin
        Q       = q_q;
        SAT     = sat_q;
        AT_MAX  = at_max;
        AT_ZERO = at_zero;
        CE      = INC & ~LOAD & ~Reset & terminal;
    end

endmodule

// File: tb/tb_mixed_radix_counter.sv
// Directed bench for mixed_radix_counter: a vector table on the default
// 4-digit 9,9,5,9 configuration plus a long up-count and a 2-digit wrap run.
module tb_mixed_radix_counter;

    logic        CLK = 1'b0;
    logic        Reset, INC, DOWN, WRAP, LOAD;
    logic [15:0] LOAD_VAL;
    logic [15:0] Q;
    logic        CE, AT_MAX, AT_ZERO, SAT;
    logic [7:0]  Q2;
    logic        CE2, AT_MAX2, AT_ZERO2, SAT2;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mixed_radix_counter #(.NUM_DIGITS(4), .MAX_LIST(32'h0000_9599)) u_dut (
        .CLK(CLK), .Reset(Reset), .INC(INC), .DOWN(DOWN), .WRAP(WRAP),
        .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .Q(Q), .CE(CE),
        .AT_MAX(AT_MAX), .AT_ZERO(AT_ZERO), .SAT(SAT)
    );

    mixed_radix_counter #(.NUM_DIGITS(2), .MAX_LIST(32'h0000_005B)) u_dut2 (
        .CLK(CLK), .Reset(Reset), .INC(INC), .DOWN(DOWN), .WRAP(WRAP),
        .LOAD(LOAD), .LOAD_VAL(8'h00), .Q(Q2), .CE(CE2),
        .AT_MAX(AT_MAX2), .AT_ZERO(AT_ZERO2), .SAT(SAT2)
    );

    typedef struct {
        logic        rst;
        logic        ld;
        logic        inc;
        logic        dn;
        logic        wr;
        logic [15:0] lv;
        logic        ce;
        logic [15:0] q;
        logic        sat;
        logic        am;
        logic        az;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic ld, logic inc, logic dn, logic wr,
                                logic [15:0] lv, logic ce, logic [15:0] q,
                                logic sat, logic am, logic az);
        vec_t v;
        v.rst = rst; v.ld = ld; v.inc = inc; v.dn = dn; v.wr = wr; v.lv = lv;
        v.ce = ce; v.q = q; v.sat = sat; v.am = am; v.az = az;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [3:0] d0, d1;
        logic       exp_ce;
        Reset = 1'b1; INC = 1'b0; DOWN = 1'b0; WRAP = 1'b1; LOAD = 1'b0; LOAD_VAL = '0;

        //                 rst ld inc dn wr  lv        ce  q        sat am az
        vecs.push_back(mk(1, 0, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 1, 16'h9599, 0, 16'h9599, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0000, 1, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h9599, 0, 16'h9599, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 1, 16'h9599, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 1, 16'h9599, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 1, 16'h9599, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 1, 16'h0100, 0, 16'h0100, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 16'h0000, 0, 16'h0099, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 1, 16'h0000, 1, 16'h9599, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 16'hFFFF, 0, 16'h9599, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 16'h1234, 0, 16'h1234, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 16'h4237, 0, 16'h4237, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0000, 0, 16'h4238, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 1, 16'h1111, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 16'h0000, 1, 16'h0000, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 0, 16'h0001, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0599, 0, 16'h0599, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 0, 16'h1000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 16'h0C0C, 0, 16'h0509, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 16'h0000, 0, 16'h0508, 0, 0, 0));

        @(posedge CLK); #1;
        foreach (vecs[i]) begin
            Reset = vecs[i].rst; LOAD = vecs[i].ld; INC = vecs[i].inc;
            DOWN = vecs[i].dn; WRAP = vecs[i].wr; LOAD_VAL = vecs[i].lv;
            #4;
            chk($sformatf("v%0d_ce", i), {31'b0, CE}, {31'b0, vecs[i].ce});
            @(posedge CLK); #1;
            chk($sformatf("v%0d_q", i), {16'b0, Q}, {16'b0, vecs[i].q});
            chk($sformatf("v%0d_sat", i), {31'b0, SAT}, {31'b0, vecs[i].sat});
            chk($sformatf("v%0d_atmax", i), {31'b0, AT_MAX}, {31'b0, vecs[i].am});
            chk($sformatf("v%0d_atzero", i), {31'b0, AT_ZERO}, {31'b0, vecs[i].az});
        end

        // Long up-count from zero: 600 steps carry digit 2 through its radix-6 range once.
        Reset = 1'b1; LOAD = 1'b0; INC = 1'b0; DOWN = 1'b0; WRAP = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0; INC = 1'b1;
        for (int c = 0; c < 600; c++) begin
            #4;
            if (CE !== 1'b0) chk("long_ce", {31'b0, CE}, 32'd0);
            @(posedge CLK); #1;
            if (Q[11:8] > 4'd5) chk("long_digit2", {28'b0, Q[11:8]}, 32'd5);
        end
        INC = 1'b0;
        chk("long_q", {16'b0, Q}, 32'h0000_1000);

        // Two-digit 5,B configuration: 72 states, then wrap to 00.
        Reset = 1'b1;
        @(posedge CLK); #1;
        Reset = 1'b0; INC = 1'b1; WRAP = 1'b1; DOWN = 1'b0;
        d0 = 4'd0; d1 = 4'd0;
        for (int c = 0; c < 75; c++) begin
            exp_ce = (d1 == 4'd5) && (d0 == 4'd11);
            #4;
            chk($sformatf("two_ce%0d", c), {31'b0, CE2}, {31'b0, exp_ce});
            @(posedge CLK); #1;
            if (d0 == 4'd11) begin
                d0 = 4'd0;
                d1 = (d1 == 4'd5) ? 4'd0 : d1 + 4'd1;
            end else begin
                d0 = d0 + 4'd1;
            end
            chk($sformatf("two_q%0d", c), {24'b0, Q2}, {24'b0, d1, d0});
            if (c == 70) chk("two_q_top", {24'b0, Q2}, 32'h5B);
            if (c == 71) chk("two_q_wrap", {24'b0, Q2}, 32'h00);
        end
        INC = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
